// File: rtl/blk_d6537a.sv
// Serial saturating arithmetic left shift: r = a * 2**s, one bit per clock.
// Signed overflow is detected one step before the sign bit would flip.
// On overflow the result saturates to the most-positive or most-negative
// value for the operand's sign, and the operation ends early.
module blk_d6537a #(
  parameter int N  = 8,
  parameter int SW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [SW-1:0] in_s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_res,
  output logic          out_ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  r_q, r_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic, shift/saturate datapath and handshake outputs.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_res   = '0;
    out_ovf   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          r_d     = in_a;
          cnt_d   = in_s;
          ovf_d   = 1'b0;
          state_d = (in_s == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // Top two bits differ: shifting again would change the sign.
        if (r_q[N-1] != r_q[N-2]) begin
          r_d     = r_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          r_d   = {r_q[N-2:0], 1'b0};
          cnt_d = cnt_q - SW'(1);
          if (cnt_q == SW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_res   = r_q;
        out_ovf   = ovf_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_blk_d6537a.sv
// Scoreboarded bench for the serial saturating left shifter (N=8, SW=4).
module tb_blk_d6537a;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [3:0] in_s = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_res;
  logic       out_ovf;

  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  bit   seen_vld = 0;
  bit   prev_vld = 0;
  logic [7:0] held_res;
  logic       held_ovf;
  exp_t sb[$];

  blk_d6537a #(.N(8), .SW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_s(in_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int req);
    tot_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
  endfunction

  // Reference: exact a*2**i in integers, saturating at the first step that leaves the 8-bit range.
  function automatic exp_t model(input logic [7:0] a, input logic [3:0] s);
    exp_t e;
    int v;
    v = int'($signed(a));
    e.ovf = 1'b0;
    e.lat = 1 + int'(s);
    for (int i = 1; i <= int'(s); i++) begin
      v = v * 2;
      if (v > 127 || v < -128) begin
        e.res = a[7] ? 8'h80 : 8'h7F;
        e.ovf = 1'b1;
        e.lat = 1 + i;
        return e;
      end
    end
    e.res = v[7:0];
    return e;
  endfunction

  // Monitor: push expectation on accept, check latency on first valid, pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(model(in_a, in_s));
        acc_cyc = cyc + 1;
      end
      if (out_valid) begin
        chk("in_ready_low_when_valid", int'(in_ready), 0);
        if (prev_vld && !seen_vld) ;
        if (!seen_vld) begin
          seen_vld = 1;
          held_res = out_res;
          held_ovf = out_ovf;
          if (sb.size() == 0) chk("unexpected_output", 1, 0);
          else chk("latency", cyc + 1 - acc_cyc, sb[0].lat);
        end else begin
          chk("stall_res_stable", int'(out_res), int'(held_res));
          chk("stall_ovf_stable", int'(out_ovf), int'(held_ovf));
        end
        if (out_ready && sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("out_res", int'(out_res), int'(e.res));
          chk("out_ovf", int'(out_ovf), int'(e.ovf));
          seen_vld = 0;
        end
      end else begin
        chk("ovf_zero_when_idle", int'(out_ovf), 0);
      end
      prev_vld = out_valid;
    end
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin n++; @(negedge clk); end
    if (n >= 60) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 60) begin n++; @(negedge clk); end
    if (n >= 60) chk({nm, "_timeout"}, 0, 1);
  endtask

  // One full operation; stall = cycles out_ready is held low in DONE.
  task automatic op(input logic [7:0] a, input logic [3:0] s, input int stall);
    in_a = a; in_s = s; in_valid = 1'b1;
    out_ready = (stall == 0);
    wait_ready("accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("result");
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_out_valid"}, int'(out_valid), 0);
    chk({nm, "_out_res"},   int'(out_res),   0);
    chk({nm, "_out_ovf"},   int'(out_ovf),   0);
    chk({nm, "_in_ready"},  int'(in_ready),  1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    op(8'h05, 4'd3, 0);
    op(8'hF0, 4'd3, 0);
    op(8'h40, 4'd1, 0);
    op(8'hBF, 4'd2, 0);
    op(8'h93, 4'd0, 0);
    op(8'h00, 4'd15, 0);
    op(8'h01, 4'd15, 0);
    op(8'h7F, 4'd0, 0);

    // Back-pressure: new operand offered during DONE must be ignored until IDLE.
    in_a = 8'h03; in_s = 4'd2; in_valid = 1'b1; out_ready = 1'b0;
    wait_ready("bp_accept");
    @(posedge clk); #1;
    in_a = 8'hC0; in_s = 4'd1;
    wait_valid("bp_result");
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after_done", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("bp_second");
    @(posedge clk); #1;

    // Reset in the second shift cycle of a=01, s=6.
    in_a = 8'h01; in_s = 4'd6; in_valid = 1'b1; out_ready = 1'b1;
    wait_ready("rst_accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle("mid_reset");
    sb.delete();
    seen_vld = 0;
    rst_n = 1'b1;
    op(8'h01, 4'd6, 0);

    // Randomized operations with random back-pressure
    for (int k = 0; k < 40; k++) begin
      logic [7:0] a;
      logic [3:0] s;
      a = 8'($urandom);
      if (k % 5 == 0) a = 8'($urandom_range(0, 3)) << 6 >> 6;
      s = 4'($urandom_range(0, 15));
      if (k % 3 == 0) s = 4'($urandom_range(0, 4));
      op(a, s, (k % 4 == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
